// File: rtl/trigout_conditioner.sv
// Trigger-out conditioner: detects rising edges on the upstream trigger-out level,
// waits a programmable delay, then emits a pulse of programmable width and polarity.
// Triggers that arrive while a delay or pulse is in progress are dropped and counted.
module trigout_conditioner #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             EN,
   input  logic             TDin,
   input  logic [CNT_W-1:0] Delay,
   input  logic [CNT_W-1:0] Width,
   input  logic             Polarity,
   output logic             TDout,
   output logic             Busy,
   output logic [7:0]       Miss_Cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      PULSE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             TDin_q;
   logic             Pulse_q, Pulse_d;
   logic [CNT_W-1:0] dly_q, dly_d;
   logic [CNT_W-1:0] wid_q, wid_d;
   logic [7:0]       miss_q, miss_d;
   logic             detect;

   // TDin_q resets high so a level already asserted at reset release is not an edge
   assign detect = TDin & ~TDin_q;

   // State, counters, pulse and miss counter registers
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= IDLE;
         TDin_q  <= 1'b1;
         Pulse_q <= 1'b0;
         dly_q   <= '0;
         wid_q   <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         TDin_q  <= TDin;
         Pulse_q <= Pulse_d;
         dly_q   <= dly_d;
         wid_q   <= wid_d;
         miss_q  <= miss_d;
      end
   end

   // Next-state, counter and pulse logic; EN low aborts to IDLE without counting misses
   always_comb begin
      state_d = state_q;
      Pulse_d = Pulse_q;
      dly_d   = dly_q;
      wid_d   = wid_q;
      miss_d  = miss_q;

      if (!EN) begin
         state_d = IDLE;
         Pulse_d = 1'b0;
      end else begin
         if (detect && (state_q != IDLE) && (miss_q != 8'hFF)) begin
            miss_d = miss_q + 8'd1;
         end

         case (state_q)
            IDLE: begin
               Pulse_d = 1'b0;
               if (detect) begin
                  dly_d   = Delay;
                  wid_d   = (Width == '0) ? CNT_W'(1) : Width;
                  state_d = (Delay == '0) ? PULSE : DELAY;
               end
            end
            DELAY: begin
               dly_d = dly_q - CNT_W'(1);
               if (dly_q == CNT_W'(1)) begin
                  state_d = PULSE;
               end
            end
            PULSE: begin
               // First PULSE cycle only arms the output, so the pulse starts one edge later
               if (wid_q == '0) begin
                  state_d = IDLE;
                  Pulse_d = 1'b0;
               end else begin
                  Pulse_d = 1'b1;
                  wid_d   = wid_q - CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               Pulse_d = 1'b0;
            end
         endcase
      end
   end

   assign TDout    = Pulse_q ^ Polarity;
   assign Busy     = (state_q != IDLE);
   assign Miss_Cnt = miss_q;

endmodule

// File: tb/tb_trigout_conditioner.sv
// Directed testbench for trigout_conditioner with hand-computed expectations.
module tb_trigout_conditioner;

   localparam int unsigned CNT_W = 16;

   logic             Clock = 1'b0;
   logic             Reset;
   logic             EN;
   logic             TDin;
   logic [CNT_W-1:0] Delay;
   logic [CNT_W-1:0] Width;
   logic             Polarity;
   logic             TDout;
   logic             Busy;
   logic [7:0]       Miss_Cnt;

   int unsigned checks = 0;
   int unsigned errors = 0;

   trigout_conditioner #(.CNT_W(CNT_W)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .EN       (EN),
      .TDin     (TDin),
      .Delay    (Delay),
      .Width    (Width),
      .Polarity (Polarity),
      .TDout    (TDout),
      .Busy     (Busy),
      .Miss_Cnt (Miss_Cnt)
   );

   // 10 ns clock
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge; outputs are sampled and inputs driven 1 ns later
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   initial begin
      Reset = 1'b1; EN = 1'b1; TDin = 1'b0;
      Delay = '0; Width = '0; Polarity = 1'b0;
      tick(); tick();
      chk("rst_tdout", 32'(TDout), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_miss", 32'(Miss_Cnt), 32'd0);
      Reset = 1'b0;
      tick();

      // Delay=0, Width=3: pulse after k+1..k+3, busy after k..k+3
      Delay = 16'd0; Width = 16'd3;
      TDin = 1'b1; tick(); TDin = 1'b0;
      chk("s1_busy_k", 32'(Busy), 32'd1);
      chk("s1_tdout_k", 32'(TDout), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("s1_tdout_k%0d", i), 32'(TDout), (i <= 3) ? 32'd1 : 32'd0);
         chk($sformatf("s1_busy_k%0d", i), 32'(Busy), (i <= 3) ? 32'd1 : 32'd0);
      end
      tick();

      // Delay=5, Width=0: single cycle after k+6, busy through k+6
      Delay = 16'd5; Width = 16'd0;
      TDin = 1'b1; tick(); TDin = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk($sformatf("s2_tdout_k%0d", i), 32'(TDout), (i == 6) ? 32'd1 : 32'd0);
         chk($sformatf("s2_busy_k%0d", i), 32'(Busy), (i <= 6) ? 32'd1 : 32'd0);
      end
      chk("s2_miss", 32'(Miss_Cnt), 32'd0);

      // Delay=4, Width=4, extra rises before edges k+2 (DELAY) and k+6 (PULSE);
      // Delay/Width rewritten mid-flight must not matter
      Delay = 16'd4; Width = 16'd4;
      TDin = 1'b1; tick(); TDin = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         TDin = (i == 2 || i == 6);
         if (i == 3) begin
            Delay = 16'd0; Width = 16'd1;
         end
         tick();
         chk($sformatf("s3_tdout_k%0d", i), 32'(TDout), (i >= 5 && i <= 8) ? 32'd1 : 32'd0);
      end
      TDin = 1'b0;
      chk("s3_busy_end", 32'(Busy), 32'd0);
      chk("s3_miss", 32'(Miss_Cnt), 32'd2);

      // EN dropped mid-pulse with Width=10
      Delay = 16'd0; Width = 16'd10;
      TDin = 1'b1; tick(); TDin = 1'b0;
      tick(); tick(); tick();
      chk("s4_tdout_mid", 32'(TDout), 32'd1);
      EN = 1'b0; tick();
      chk("s4_tdout_off", 32'(TDout), 32'd0);
      chk("s4_busy_off", 32'(Busy), 32'd0);
      TDin = 1'b1; tick(); TDin = 1'b0; tick();
      chk("s4_busy_dis", 32'(Busy), 32'd0);
      chk("s4_miss_dis", 32'(Miss_Cnt), 32'd2);
      EN = 1'b1; Width = 16'd1;
      TDin = 1'b1; tick(); TDin = 1'b0;
      chk("s4_busy_re", 32'(Busy), 32'd1);
      tick();
      chk("s4_tdout_re", 32'(TDout), 32'd1);
      tick();
      chk("s4_tdout_re_end", 32'(TDout), 32'd0);
      chk("s4_busy_re_end", 32'(Busy), 32'd0);

      // TDin high through reset release, active-low output
      Polarity = 1'b1; TDin = 1'b1; Reset = 1'b1;
      tick(); tick();
      chk("s5_rst_tdout", 32'(TDout), 32'd1);
      chk("s5_rst_miss", 32'(Miss_Cnt), 32'd0);
      Reset = 1'b0;
      tick(); tick(); tick();
      chk("s5_held_tdout", 32'(TDout), 32'd1);
      chk("s5_held_busy", 32'(Busy), 32'd0);
      TDin = 1'b0; tick();
      TDin = 1'b1; tick();
      chk("s5_acc_busy", 32'(Busy), 32'd1);
      chk("s5_acc_tdout", 32'(TDout), 32'd1);
      tick();
      chk("s5_pulse_low", 32'(TDout), 32'd0);
      Polarity = 1'b0; #1;
      chk("s5_pol_comb", 32'(TDout), 32'd1);
      Polarity = 1'b1;
      tick();
      chk("s5_pulse_end", 32'(TDout), 32'd1);
      TDin = 1'b0; Polarity = 1'b0; tick();

      // 300 rejected triggers during a long pulse saturate Miss_Cnt
      Delay = 16'd0; Width = 16'd1000;
      TDin = 1'b1; tick(); TDin = 1'b0; tick();
      for (int i = 1; i <= 300; i++) begin
         TDin = 1'b1; tick();
         TDin = 1'b0; tick();
         if (i == 200) chk("s6_miss_200", 32'(Miss_Cnt), 32'd200);
         if (i == 255) chk("s6_miss_255", 32'(Miss_Cnt), 32'd255);
      end
      chk("s6_miss_sat", 32'(Miss_Cnt), 32'd255);
      chk("s6_busy", 32'(Busy), 32'd1);
      Reset = 1'b1; tick();
      chk("s6_rst_miss", 32'(Miss_Cnt), 32'd0);
      chk("s6_rst_busy", 32'(Busy), 32'd0);
      chk("s6_rst_tdout", 32'(TDout), 32'd0);
      Reset = 1'b0; tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
